// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: FSM state encoding and default width.
package counter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage : counter_pkg

// File: rtl/tff_cell.sv
// One counter bit: toggle flip-flop with synchronous parallel load (load wins over toggle).
module tff_cell (
  input  logic clk,
  input  logic clear,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule : tff_cell

// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer: load, count to zero, pulse tc, optional periodic reload.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] t;
  logic             ld_q;
  logic             dec;
  logic             tc_nx;
  logic             q_zero;
  logic             q_one;

  assign q_zero = (q == '0);
  assign q_one  = (q == WIDTH'(1));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state <= state_nx;
      tc    <= tc_nx;
      if (load) begin
        reload <= load_val;
      end
    end
  end

  always_comb begin
    state_nx = state;
    tc_nx    = 1'b0;
    ld_q     = 1'b0;
    ld_data  = load_val;
    dec      = 1'b0;
    if (load) begin
      ld_q     = 1'b1;
      state_nx = IDLE;
    end else if (stop) begin
      state_nx = IDLE;
    end else if (state == IDLE) begin
      if (start && !q_zero) begin
        state_nx = COUNT;
      end
    end else if (!q_zero) begin
      dec = 1'b1;
      if (q_one) begin
        tc_nx = 1'b1;
        if (!auto_reload) begin
          state_nx = IDLE;
        end
      end
    end else begin
      // Zero is only reachable in COUNT on the periodic path: restart from reload.
      ld_q    = 1'b1;
      ld_data = reload;
      if (reload == '0) begin
        state_nx = IDLE;
      end
    end
  end

  // Borrow propagate: a bit toggles when every lower bit is 0.
  always_comb begin
    t[0] = dec;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & ~q[i-1];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    tff_cell u_cell (
      .clk   (clk),
      .clear (clear),
      .t     (t[g]),
      .ld    (ld_q),
      .d     (ld_data[g]),
      .q     (q[g])
    );
  end

  assign busy = (state == COUNT);

endmodule : down_counter_timer
